// File: rtl/stack_return_handler.sv
// Stack-pull half of the 6502 return protocol: RTI restores PSR/PCL/PCH,
// RTS restores PCL/PCH and then bumps PC by one.
module stack_return_handler #(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic        mem_rti,
  input  logic        mem_rts,
  input  logic        mem_ready,
  input  logic [7:0]  mem_data_in,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  input  logic [7:0]  rgf_s,
  output logic [7:0]  rgf_data,
  output logic        rgf_set_psr,
  output logic        rgf_set_pcl,
  output logic        rgf_set_pch,
  output logic        rgf_inc_pc,
  output logic        rgf_popped,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PULL_PSR = 3'd1,
    PULL_PCL = 3'd2,
    PULL_PCH = 3'd3,
    INC_PC   = 3'd4
  } state_t;

  state_t state_r;
  logic   r_is_rti;
  logic   pull_s;
  logic   accept_s;
  logic [7:0] next_s_s;

  // Sequence FSM; strobes arriving outside IDLE are dropped, not queued.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_r  <= IDLE;
      r_is_rti <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (mem_rti) begin
            state_r  <= PULL_PSR;
            r_is_rti <= 1'b1;
          end else if (mem_rts) begin
            state_r  <= PULL_PCL;
            r_is_rti <= 1'b0;
          end else begin
            state_r  <= IDLE;
          end
        end
        PULL_PSR: state_r <= mem_ready ? PULL_PCL : PULL_PSR;
        PULL_PCL: state_r <= mem_ready ? PULL_PCH : PULL_PCL;
        PULL_PCH: begin
          if (mem_ready) begin
            state_r <= r_is_rti ? IDLE : INC_PC;
          end else begin
            state_r <= PULL_PCH;
          end
        end
        INC_PC:  state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // S is pre-incremented per pull; the 8-bit add wraps FF to 00 inside the page.
  assign next_s_s = rgf_s + 8'd1;
  assign pull_s   = (state_r == PULL_PSR) || (state_r == PULL_PCL) || (state_r == PULL_PCH);
  assign accept_s = pull_s && mem_ready;

  // Output decode; the read handshake completes in the same cycle as mem_ready.
  always_comb begin
    mem_read    = pull_s;
    mem_addr    = pull_s ? {STACK_PAGE, next_s_s} : 16'h0000;
    rgf_popped  = accept_s;
    rgf_set_psr = accept_s && (state_r == PULL_PSR);
    rgf_set_pcl = accept_s && (state_r == PULL_PCL);
    rgf_set_pch = accept_s && (state_r == PULL_PCH);
    rgf_inc_pc  = (state_r == INC_PC);
    busy        = (state_r != IDLE);
    done        = (accept_s && (state_r == PULL_PCH) && r_is_rti) || (state_r == INC_PC);
    case (state_r)
      // Restored PSR always has bit 5 set and B clear.
      PULL_PSR: rgf_data = {mem_data_in[7:6], 1'b1, 1'b0, mem_data_in[3:0]};
      PULL_PCL: rgf_data = mem_data_in;
      PULL_PCH: rgf_data = mem_data_in;
      default:  rgf_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_stack_return_handler.sv
// Scoreboard bench for stack_return_handler with a small register-file and stack model.
module tb_stack_return_handler;

  logic        clk;
  logic        rst_x;
  logic        mem_rti;
  logic        mem_rts;
  logic        mem_ready;
  logic [7:0]  mem_data_in;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic [7:0]  rgf_s;
  logic [7:0]  rgf_data;
  logic        rgf_set_psr;
  logic        rgf_set_pcl;
  logic        rgf_set_pch;
  logic        rgf_inc_pc;
  logic        rgf_popped;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [5:0]  str;   // {psr, pcl, pch, inc_pc, popped, done}
  } ev_t;

  ev_t exp_q[$];
  int  checks;
  int  errors;

  logic [7:0]  stack_mem [256];
  logic [7:0]  s_m;
  logic [15:0] pc_m;
  logic [7:0]  psr_m;
  logic        load_en;
  logic [7:0]  load_s;
  logic [5:0]  strobes;

  stack_return_handler #(.STACK_PAGE(8'h01)) dut (
    .clk(clk), .rst_x(rst_x), .mem_rti(mem_rti), .mem_rts(mem_rts),
    .mem_ready(mem_ready), .mem_data_in(mem_data_in), .mem_addr(mem_addr),
    .mem_read(mem_read), .rgf_s(rgf_s), .rgf_data(rgf_data),
    .rgf_set_psr(rgf_set_psr), .rgf_set_pcl(rgf_set_pcl), .rgf_set_pch(rgf_set_pch),
    .rgf_inc_pc(rgf_inc_pc), .rgf_popped(rgf_popped), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data_in = stack_mem[mem_addr[7:0]];
  assign rgf_s       = s_m;
  assign strobes     = {rgf_set_psr, rgf_set_pcl, rgf_set_pch, rgf_inc_pc, rgf_popped, done};

  // Register-file model reacting to the DUT strobes.
  always @(posedge clk) begin
    if (load_en) begin
      s_m   <= load_s;
      pc_m  <= 16'h0000;
      psr_m <= 8'h00;
    end else begin
      if (rgf_popped)  s_m <= s_m + 8'd1;
      if (rgf_set_psr) psr_m <= rgf_data;
      if (rgf_set_pcl) pc_m[7:0] <= rgf_data;
      if (rgf_set_pch) pc_m[15:8] <= rgf_data;
      if (rgf_inc_pc)  pc_m <= pc_m + 16'd1;
    end
  end

  // Scoreboard: every strobing cycle must match the next expected event.
  always @(negedge clk) begin
    ev_t e;
    #2;
    if (rst_x && (strobes != 6'b000000)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe got addr=%h data=%h str=%b want none", mem_addr, rgf_data, strobes);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, rgf_data, strobes} !== {e.addr, e.data, e.str}) begin
          errors++;
          $display("FAIL strobe_event got addr=%h data=%h str=%b want addr=%h data=%h str=%b",
                   mem_addr, rgf_data, strobes, e.addr, e.data, e.str);
        end
      end
    end
  end

  task automatic push_ev(input logic [15:0] a, input logic [7:0] d, input logic [5:0] s);
    ev_t e;
    e.addr = a; e.data = d; e.str = s;
    exp_q.push_back(e);
  endtask

  task automatic set_sp(input logic [7:0] v);
    @(negedge clk);
    load_s  = v;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Fire a request, optionally stall mem_ready, and count cycles until done.
  task automatic run_seq(input logic rti, input logic rts, input int stall_at, input int stall_n,
                         input logic [15:0] stall_addr, input logic rts_mid, output int lat);
    logic seen;
    seen = 1'b0;
    lat  = 0;
    @(negedge clk);
    mem_rti = rti; mem_rts = rts; mem_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      lat++;
      mem_rti   = 1'b0;
      mem_rts   = rts_mid && (lat == 1);
      mem_ready = !((lat >= stall_at) && (lat < stall_at + stall_n));
      #1;
      if (!mem_ready) begin
        checks++;
        if ({mem_read, mem_addr, strobes} !== {1'b1, stall_addr, 6'b000000}) begin
          errors++;
          $display("FAIL stall_hold got read=%b addr=%h str=%b want read=1 addr=%h str=000000",
                   mem_read, mem_addr, strobes, stall_addr);
        end
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    mem_rts = 1'b0; mem_ready = 1'b1;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout got no done want done within 20 cycles");
    end
    @(negedge clk);
  endtask

  task automatic check_final(input string nm, input int lat, input int exp_lat,
                             input logic [7:0] es, input logic [15:0] epc);
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s_latency got %0d want %0d", nm, lat, exp_lat);
    end
    checks++;
    if ({s_m, pc_m} !== {es, epc}) begin
      errors++;
      $display("FAIL %s_regs got s=%h pc=%h want s=%h pc=%h", nm, s_m, pc_m, es, epc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got %0d events left want 0", nm, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, mem_read, mem_addr, rgf_data, strobes} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b addr=%h data=%h str=%b want all 0", busy, mem_addr, rgf_data, strobes);
    end
    @(negedge clk);
    rst_x = 1'b1;
  endtask

  task automatic push_rti_fa();
    push_ev(16'h01FB, 8'hEF, 6'b100010);
    push_ev(16'h01FC, 8'h34, 6'b010010);
    push_ev(16'h01FD, 8'h12, 6'b001011);
  endtask

  task automatic test_rti();
    int lat;
    set_sp(8'hFA);
    push_rti_fa();
    run_seq(1'b1, 1'b0, 0, 0, 16'h0000, 1'b0, lat);
    check_final("rti", lat, 3, 8'hFD, 16'h1234);
    checks++;
    if (psr_m !== 8'hEF) begin
      errors++;
      $display("FAIL rti_psr got %h want ef", psr_m);
    end
  endtask

  task automatic test_rts();
    int lat;
    set_sp(8'hFD);
    push_ev(16'h01FE, 8'hFF, 6'b010010);
    push_ev(16'h01FF, 8'h80, 6'b001010);
    push_ev(16'h0000, 8'h00, 6'b000101);
    run_seq(1'b0, 1'b1, 0, 0, 16'h0000, 1'b0, lat);
    check_final("rts", lat, 3, 8'hFF, 16'h8100);
  endtask

  task automatic test_rts_wrap();
    int lat;
    set_sp(8'hFE);
    push_ev(16'h01FF, 8'h80, 6'b010010);
    push_ev(16'h0100, 8'h5A, 6'b001010);
    push_ev(16'h0000, 8'h00, 6'b000101);
    run_seq(1'b0, 1'b1, 0, 0, 16'h0000, 1'b0, lat);
    check_final("rts_wrap", lat, 3, 8'h00, 16'h5A81);
  endtask

  task automatic test_stall();
    int lat;
    set_sp(8'hFA);
    push_rti_fa();
    run_seq(1'b1, 1'b0, 2, 2, 16'h01FC, 1'b0, lat);
    check_final("stall", lat, 5, 8'hFD, 16'h1234);
  endtask

  task automatic test_conflict();
    int lat;
    set_sp(8'hFA);
    push_rti_fa();
    run_seq(1'b1, 1'b1, 0, 0, 16'h0000, 1'b1, lat);
    repeat (4) @(negedge clk);
    check_final("conflict", lat, 3, 8'hFD, 16'h1234);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL conflict_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    set_sp(8'hFD);
    @(negedge clk);
    mem_rts = 1'b1;
    @(negedge clk);
    mem_rts = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if ({busy, mem_read, mem_addr} !== {1'b1, 1'b1, 16'h01FE}) begin
      errors++;
      $display("FAIL abort_pre got busy=%b read=%b addr=%h want busy=1 read=1 addr=01fe", busy, mem_read, mem_addr);
    end
    rst_x = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_read, mem_addr, rgf_data, strobes} !== 36'd0) begin
      errors++;
      $display("FAIL abort_outputs got busy=%b addr=%h data=%h str=%b want all 0", busy, mem_addr, rgf_data, strobes);
    end
    @(negedge clk);
    rst_x = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b want 0", busy);
    end
    set_sp(8'hFD);
    push_ev(16'h01FE, 8'hFF, 6'b010010);
    push_ev(16'h01FF, 8'h80, 6'b001010);
    push_ev(16'h0000, 8'h00, 6'b000101);
    run_seq(1'b0, 1'b1, 0, 0, 16'h0000, 1'b0, lat);
    check_final("after_reset", lat, 3, 8'hFF, 16'h8100);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_x = 1'b0; mem_rti = 1'b0; mem_rts = 1'b0; mem_ready = 1'b1;
    load_en = 1'b0; load_s = 8'h00;
    for (int i = 0; i < 256; i++) stack_mem[i] = 8'(i);
    stack_mem[8'hFB] = 8'hFF;
    stack_mem[8'hFC] = 8'h34;
    stack_mem[8'hFD] = 8'h12;
    stack_mem[8'hFE] = 8'hFF;
    stack_mem[8'hFF] = 8'h80;
    stack_mem[8'h00] = 8'h5A;
    repeat (2) @(negedge clk);
    test_reset();
    test_rti();
    test_rts();
    test_rts_wrap();
    test_stall();
    test_conflict();
    test_reset_abort();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
